// File: rtl/regs_wb_pkg.sv
// Shared widths, arbiter FSM states and the B FIFO entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regs_wb_pkg;

    localparam int REG_W    = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/regs_wb_arbiter_if.sv
// Bundles the A port, the B handshake and the register file write port.
// Latency: n/a (wiring only).
// Backpressure: B is throttled by b_ready; A is throttled by a_stall.
interface regs_wb_arbiter_if;

    logic                             a_we;
    logic [regs_wb_pkg::ADDR_W-1:0]   a_addr;
    logic [regs_wb_pkg::REG_W-1:0]    a_data;
    logic                             a_stall;
    logic                             b_valid;
    logic                             b_ready;
    logic [regs_wb_pkg::ADDR_W-1:0]   b_addr;
    logic [regs_wb_pkg::REG_W-1:0]    b_data;
    logic                             wt_en;
    logic [regs_wb_pkg::ADDR_W-1:0]   wt_addr;
    logic [regs_wb_pkg::REG_W-1:0]    wt_data;
    logic [regs_wb_pkg::NUM_REGS-1:0] busy;

    // Requester side: the pipeline stages and, in simulation, the bench.
    modport master (
        output a_we, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_stall, b_ready, wt_en, wt_addr, wt_data, busy
    );

    // Arbiter side.
    modport slave (
        input  a_we, a_addr, a_data, b_valid, b_addr, b_data,
        output a_stall, b_ready, wt_en, wt_addr, wt_data, busy
    );

endinterface

// File: rtl/regs_wb_fifo.sv
// DEPTH-entry FIFO of B writes with per-entry live bits, squash-by-address and a busy bitmap.
// Latency: an entry is visible at the head the cycle after the push edge.
// Backpressure: full is exported; the caller must not push while full or pop while empty.
module regs_wb_fifo
    import regs_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  wb_entry_t           push_entry,
    input  logic                pop,
    input  logic                squash,
    input  logic [ADDR_W-1:0]   squash_addr,
    output wb_entry_t           head,
    output logic                empty,
    output logic                full,
    output logic [NUM_REGS-1:0] busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [DEPTH-1:0] occupied;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign head  = mem[rd_ptr];

    // A slot holds a pending entry when its distance from the read pointer is below the count.
    always_comb begin
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] off;
            off = PTR_W'(i) - rd_ptr;
            occupied[i] = ({1'b0, off} < count);
        end
    end

    // Busy bitmap: OR of the addresses of all pending live entries; r0 is never busy.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && mem[i].live) begin
                busy[mem[i].addr] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

    // Storage, pointers and count; squash only touches entries pending before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (squash) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (occupied[i] && (mem[i].addr == squash_addr)) begin
                        mem[i].live <= 1'b0;
                    end
                end
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Shares the register file write port between fixed-priority A and FIFO-buffered B.
// Latency: A 1 cycle to wt_*; B at least 2 cycles (accept edge, pop edge).
// Backpressure: b_ready = !full; a_stall for one cycle after STARVE_LIMIT A wins over a waiting B.
module regs_wb_arbiter
    import regs_wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    regs_wb_arbiter_if.slave bus
);

    localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic              a_win;
    logic              pop;
    logic              push;
    logic              out_of_reset;
    wb_entry_t         head;
    wb_entry_t         push_entry;
    logic              empty;
    logic              full;
    logic [NUM_REGS-1:0] busy;

    logic              wt_en_q;
    logic [ADDR_W-1:0] wt_addr_q;
    logic [REG_W-1:0]  wt_data_q;
    logic              a_stall_q;

    // A only wins in NORMAL and only for a real register; otherwise the head drains.
    assign a_win = (state == NORMAL) && bus.a_we && (bus.a_addr != '0);
    assign pop   = !a_win && !empty;

    // r0 writes complete the handshake but are dropped instead of enqueued.
    assign bus.b_ready = out_of_reset && !full;
    assign push        = bus.b_valid && bus.b_ready && (bus.b_addr != '0);
    assign push_entry  = '{live: 1'b1, addr: bus.b_addr, data: bus.b_data};

    regs_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .squash      (a_win),
        .squash_addr (bus.a_addr),
        .head        (head),
        .empty       (empty),
        .full        (full),
        .busy        (busy)
    );

    assign bus.busy    = busy;
    assign bus.wt_en   = wt_en_q;
    assign bus.wt_addr = wt_addr_q;
    assign bus.wt_data = wt_data_q;
    assign bus.a_stall = a_stall_q;

    // Starvation FSM: count A wins over a waiting FIFO, force one drain cycle at the limit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            NORMAL: begin
                if (a_win && !empty) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = FORCE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (pop) begin
                    cnt_nxt = '0;
                end
            end
            FORCE: begin
                state_nxt = NORMAL;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = NORMAL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state and starvation count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORMAL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered write port and stall; addr/data hold when no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_en_q      <= 1'b0;
            wt_addr_q    <= '0;
            wt_data_q    <= '0;
            a_stall_q    <= 1'b0;
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            a_stall_q    <= (state_nxt == FORCE);
            wt_en_q      <= a_win || (pop && head.live);
            if (a_win) begin
                wt_addr_q <= bus.a_addr;
                wt_data_q <= bus.a_data;
            end else if (pop && head.live) begin
                wt_addr_q <= head.addr;
                wt_data_q <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed and randomized checks of regs_wb_arbiter against a queue-based model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_regs_wb_arbiter;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    typedef struct {
        bit        live;
        bit [4:0]  addr;
        bit [31:0] data;
    } ent_t;

    logic clk;
    logic rst_n;
    regs_wb_arbiter_if bus ();

    regs_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: pending B writes in arrival order plus the starvation bookkeeping.
    ent_t      q[$];
    bit        m_force;
    int        m_cnt;
    bit        m_ready_en;
    bit        exp_en;
    bit [4:0]  exp_addr;
    bit [31:0] exp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        foreach (q[i]) if (q[i].live) b[q[i].addr] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    function automatic bit model_ready();
        return m_ready_en && (q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        q.delete();
        m_force    = 0;
        m_cnt      = 0;
        m_ready_en = 0;
        exp_en     = 0;
        exp_addr   = '0;
        exp_data   = '0;
    endtask

    task automatic issue(input ent_t e);
        exp_en = e.live;
        if (e.live) begin
            exp_addr = e.addr;
            exp_data = e.data;
        end
    endtask

    // Apply one clock edge's worth of arbitration rules to the model, using pre-edge inputs.
    task automatic model_update();
        bit   acc;
        ent_t e;
        if (!rst_n) return;
        acc = bus.b_valid && model_ready() && (bus.b_addr != 0);
        exp_en = 0;
        if (m_force) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                issue(e);
            end
            m_force = 0;
            m_cnt   = 0;
        end else if (bus.a_we && bus.a_addr != 0) begin
            e.live = 1; e.addr = bus.a_addr; e.data = bus.a_data;
            issue(e);
            if (q.size() > 0) begin
                if (m_cnt == STARVE - 1) m_force = 1;
                else m_cnt++;
            end
            foreach (q[i]) begin
                if (q[i].addr == bus.a_addr) begin
                    e = q[i];
                    e.live = 0;
                    q[i] = e;
                end
            end
        end else if (q.size() > 0) begin
            e = q.pop_front();
            issue(e);
            m_cnt = 0;
        end
        if (acc) begin
            e.live = 1; e.addr = bus.b_addr; e.data = bus.b_data;
            q.push_back(e);
        end
        m_ready_en = 1;
    endtask

    task automatic compare_all();
        chk("wt_en", {31'b0, bus.wt_en}, {31'b0, exp_en});
        if (exp_en) begin
            chk("wt_addr", {27'b0, bus.wt_addr}, {27'b0, exp_addr});
            chk("wt_data", bus.wt_data, exp_data);
        end
        chk("a_stall", {31'b0, bus.a_stall}, {31'b0, m_force});
        chk("b_ready", {31'b0, bus.b_ready}, {31'b0, model_ready()});
        chk("busy", bus.busy, model_busy());
    endtask

    // Inputs are driven at the falling edge; outputs are compared at the next falling edge.
    task automatic cycle();
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit awe, input int aaddr, input int adata,
                         input bit bv, input int baddr, input int bdata);
        bus.a_we    = awe;
        bus.a_addr  = 5'(aaddr);
        bus.a_data  = 32'(adata);
        bus.b_valid = bv;
        bus.b_addr  = 5'(baddr);
        bus.b_data  = 32'(bdata);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        chk("rst_wt_en", {31'b0, bus.wt_en}, 32'd0);
        chk("rst_wt_addr", {27'b0, bus.wt_addr}, 32'd0);
        chk("rst_wt_data", bus.wt_data, 32'd0);
        chk("rst_a_stall", {31'b0, bus.a_stall}, 32'd0);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_b_ready", {31'b0, bus.b_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", {31'b0, bus.b_ready}, 32'd0);
        cycle();
        chk("ready_after_edge", {31'b0, bus.b_ready}, 32'd1);

        // A write r5.
        drive(1, 5, 32'h1234, 0, 0, 0);
        cycle();
        chk("a_wt_en", {31'b0, bus.wt_en}, 32'd1);
        chk("a_wt_addr", {27'b0, bus.wt_addr}, 32'd5);
        chk("a_wt_data", bus.wt_data, 32'h1234);
        chk("a_busy", bus.busy, 32'd0);

        // B write r3 with A idle: two-cycle latency.
        drive(0, 0, 0, 1, 3, 32'hAAAA);
        cycle();
        chk("b_busy_set", bus.busy, 32'h8);
        chk("b_no_wt_yet", {31'b0, bus.wt_en}, 32'd0);
        idle();
        cycle();
        chk("b_busy_clr", bus.busy, 32'd0);
        chk("b_wt_addr", {27'b0, bus.wt_addr}, 32'd3);
        chk("b_wt_data", bus.wt_data, 32'hAAAA);

        // WAW squash on r7.
        drive(0, 0, 0, 1, 7, 1);
        cycle();
        chk("sq_busy_set", bus.busy, 32'h80);
        drive(1, 7, 2, 0, 0, 0);
        cycle();
        chk("sq_busy_clr", bus.busy, 32'd0);
        chk("sq_a_data", bus.wt_data, 32'd2);
        idle();
        cycle();
        chk("sq_no_write", {31'b0, bus.wt_en}, 32'd0);

        // Starvation: r9 waits while A writes r10 every cycle.
        drive(0, 0, 0, 1, 9, 32'h99);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 10, i, 0, 0, 0);
            cycle();
        end
        chk("starve_no_stall_3", {31'b0, bus.a_stall}, 32'd0);
        drive(1, 10, 3, 0, 0, 0);
        cycle();
        chk("starve_stall", {31'b0, bus.a_stall}, 32'd1);
        drive(1, 10, 4, 0, 0, 0);
        cycle();
        chk("starve_stall_drop", {31'b0, bus.a_stall}, 32'd0);
        chk("starve_wt_addr", {27'b0, bus.wt_addr}, 32'd9);
        chk("starve_wt_data", bus.wt_data, 32'h99);
        idle();
        cycle();

        // Fill to DEPTH, then pop alone, then push and pop together.
        drive(1, 1, 32'h11, 1, 11, 32'hB11);
        cycle();
        drive(1, 1, 32'h12, 1, 12, 32'hB12);
        cycle();
        chk("full_b_ready", {31'b0, bus.b_ready}, 32'd0);
        chk("full_busy", bus.busy, 32'h1800);
        drive(0, 0, 0, 1, 13, 32'hB13);
        cycle();
        chk("pop1_addr", {27'b0, bus.wt_addr}, 32'd11);
        chk("pop1_ready", {31'b0, bus.b_ready}, 32'd1);
        drive(0, 0, 0, 1, 13, 32'hB13);
        cycle();
        chk("pushpop_addr", {27'b0, bus.wt_addr}, 32'd12);
        chk("pushpop_busy", bus.busy, 32'h2000);
        drive(1, 1, 32'h21, 1, 0, 32'hDEAD);
        cycle();
        chk("r0_push_busy", bus.busy, 32'h2000);
        idle();
        cycle();
        chk("pop3_addr", {27'b0, bus.wt_addr}, 32'd13);
        chk("pop3_data", bus.wt_data, 32'hB13);

        // Reset mid-stream with two pending entries.
        drive(1, 1, 1, 1, 20, 32'h20);
        cycle();
        drive(1, 1, 2, 1, 21, 32'h21);
        cycle();
        chk("pre_rst_busy", bus.busy, 32'h300000);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst_wt_en", {31'b0, bus.wt_en}, 32'd0);
        chk("mrst_busy", bus.busy, 32'd0);
        chk("mrst_b_ready", {31'b0, bus.b_ready}, 32'd0);
        idle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("post_rst_no_wt", {31'b0, bus.wt_en}, 32'd0);
        end

        // Randomized traffic on a narrow address range to provoke squashes and starvation.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
            cycle();
        end
        idle();
        for (int i = 0; i < 6; i++) cycle();
        chk("drain_busy", bus.busy, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
